mem_port_arbiter: RTL and testbench

- Shares one 32-bit memory port between two requesters:
  - instruction-fetch (IF)
  - load/store unit (LS)
- Sits between the program-counter/instruction-fetch path and the data-access path on one side, and the unified memory on the other.
- Allows one outstanding transaction, tolerates variable memory latency, and routes each response back to its owner.
- LS has fixed priority; a starvation counter guarantees IF forward progress.

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/arb_starve_cnt.sv | 41 ++++
 rtl/mem_port_arbiter.sv | 215 +++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state/owner types and constants for the memory-port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY_IF,
        BUSY_LS
    } arb_state_t;

    typedef enum logic {
        OWN_IF,
        OWN_LS
    } owner_t;

    localparam logic [3:0] BE_FULL = 4'hF;
    localparam int         WAIT_W  = 4;
    localparam int         TO_W    = 7;

endpackage

// File: rtl/arb_starve_cnt.sv
// arb_starve_cnt: counts LS grants that beat a waiting IF request and raises
// force_if_o once IF has lost MAX_WAIT times in a row.
module arb_starve_cnt
    import mem_arb_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic ls_gnt_i,
    input  logic if_gnt_i,
    input  logic if_req_i,
    output logic force_if_o
);

    localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0] wait_cnt_q;
    logic [WAIT_W-1:0] wait_cnt_d;

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (if_gnt_i) begin
            wait_cnt_d = '0;
        end else if (ls_gnt_i && if_req_i && (wait_cnt_q != MAX_WAIT_C)) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign force_if_o = (wait_cnt_q == MAX_WAIT_C);

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: one outstanding memory transaction shared by IF and LS, LS first.
// Define MEM_ARB_TIMEOUT_EN to abort transactions whose mem_ack never arrives.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W         = 12,
    parameter int DATA_W         = 32,
    parameter int MAX_WAIT       = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_err,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    input  logic [3:0]        ls_be,
    output logic              ls_gnt,
    output logic              ls_rvalid,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              ls_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_be,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_bad_max_wait
        $error("mem_port_arbiter: MAX_WAIT must be within 1..15");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > (1 << TO_W)) begin : g_bad_timeout
        $error("mem_port_arbiter: TIMEOUT_CYCLES does not fit the timeout counter");
    end

    arb_state_t        state_q,     state_d;
    logic              mem_req_q,   mem_req_d;
    logic              mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]        mem_be_q,    mem_be_d;
    logic              if_rvalid_q, if_rvalid_d;
    logic              ls_rvalid_q, ls_rvalid_d;
    logic [DATA_W-1:0] if_rdata_q,  if_rdata_d;
    logic [DATA_W-1:0] ls_rdata_q,  ls_rdata_d;
    logic              force_if;
    logic              fin;
    logic              fin_err;
    owner_t            owner;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            if_err_q, if_err_d;
    logic            ls_err_q, ls_err_d;
`endif

    arb_starve_cnt #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve (
        .clk        (clk),
        .rst        (rst),
        .ls_gnt_i   (ls_gnt),
        .if_gnt_i   (if_gnt),
        .if_req_i   (if_req),
        .force_if_o (force_if)
    );

    assign owner = (state_q == BUSY_LS) ? OWN_LS : OWN_IF;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        if_rvalid_d = 1'b0;
        ls_rvalid_d = 1'b0;
        if_rdata_d  = if_rdata_q;
        ls_rdata_d  = ls_rdata_q;
        if_gnt      = 1'b0;
        ls_gnt      = 1'b0;
        fin         = 1'b0;
        fin_err     = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
        to_cnt_d    = '0;
        if_err_d    = if_err_q;
        ls_err_d    = ls_err_q;
`endif

        unique case (state_q)
            IDLE: begin
                // Grants are combinational, so they are masked while reset is held.
                if (!rst) begin
                    if (ls_req && !(if_req && force_if)) begin
                        ls_gnt      = 1'b1;
                        state_d     = BUSY_LS;
                        mem_req_d   = 1'b1;
                        mem_we_d    = ls_we;
                        mem_addr_d  = ls_addr;
                        mem_wdata_d = ls_wdata;
                        mem_be_d    = ls_be;
                    end else if (if_req) begin
                        if_gnt      = 1'b1;
                        state_d     = BUSY_IF;
                        mem_req_d   = 1'b1;
                        mem_we_d    = 1'b0;
                        mem_addr_d  = if_addr;
                        mem_wdata_d = '0;
                        mem_be_d    = BE_FULL;
                    end
                end
            end
            BUSY_IF, BUSY_LS: begin
`ifdef MEM_ARB_TIMEOUT_EN
                to_cnt_d = to_cnt_q + 1'b1;
                if (to_cnt_q == TO_LAST) begin
                    fin     = 1'b1;
                    fin_err = 1'b1;
                end else begin
                    fin = mem_ack;
                end
`else
                fin = mem_ack;
`endif
            end
            default: state_d = IDLE;
        endcase

        if (fin) begin
            state_d   = IDLE;
            mem_req_d = 1'b0;
            if (owner == OWN_LS) begin
                ls_rvalid_d = 1'b1;
                ls_rdata_d  = (fin_err || mem_we_q) ? '0 : mem_rdata;
`ifdef MEM_ARB_TIMEOUT_EN
                ls_err_d    = fin_err;
`endif
            end else begin
                if_rvalid_d = 1'b1;
                if_rdata_d  = fin_err ? '0 : mem_rdata;
`ifdef MEM_ARB_TIMEOUT_EN
                if_err_d    = fin_err;
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            if_rvalid_q <= 1'b0;
            ls_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            ls_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            if_rvalid_q <= if_rvalid_d;
            ls_rvalid_q <= ls_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            ls_rdata_q  <= ls_rdata_d;
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt_q <= '0;
            if_err_q <= 1'b0;
            ls_err_q <= 1'b0;
        end else begin
            to_cnt_q <= to_cnt_d;
            if_err_q <= if_err_d;
            ls_err_q <= ls_err_d;
        end
    end

    assign if_err = if_err_q;
    assign ls_err = ls_err_q;
`else
    assign if_err = 1'b0;
    assign ls_err = 1'b0;
`endif

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;
    assign if_rvalid = if_rvalid_q;
    assign ls_rvalid = ls_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign ls_rdata  = ls_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: table-driven cycle vectors plus hand-written sequences for
// starvation, asynchronous reset and (with MEM_ARB_TIMEOUT_EN) the timeout abort.
module tb_mem_port_arbiter;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;
    logic              if_err;
    logic              ls_req;
    logic              ls_we;
    logic [ADDR_W-1:0] ls_addr;
    logic [DATA_W-1:0] ls_wdata;
    logic [3:0]        ls_be;
    logic              ls_gnt;
    logic              ls_rvalid;
    logic [DATA_W-1:0] ls_rdata;
    logic              ls_err;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [3:0]        mem_be;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    mem_port_arbiter #(
        .ADDR_W         (ADDR_W),
        .DATA_W         (DATA_W),
        .MAX_WAIT       (4),
`ifdef MEM_ARB_TIMEOUT_EN
        .TIMEOUT_CYCLES (8)
`else
        .TIMEOUT_CYCLES (64)
`endif
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .if_err    (if_err),
        .ls_req    (ls_req),
        .ls_we     (ls_we),
        .ls_addr   (ls_addr),
        .ls_wdata  (ls_wdata),
        .ls_be     (ls_be),
        .ls_gnt    (ls_gnt),
        .ls_rvalid (ls_rvalid),
        .ls_rdata  (ls_rdata),
        .ls_err    (ls_err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        if_req;
        logic [11:0] if_addr;
        logic        ls_req;
        logic        ls_we;
        logic [11:0] ls_addr;
        logic [31:0] ls_wdata;
        logic [3:0]  ls_be;
        logic        mem_ack;
        logic [31:0] mem_rdata;
        logic        e_if_gnt;
        logic        e_ls_gnt;
        logic        e_mem_req;
        logic        e_mem_we;
        logic [11:0] e_mem_addr;
        logic [31:0] e_mem_wdata;
        logic [3:0]  e_mem_be;
        logic        e_if_rvalid;
        logic [31:0] e_if_rdata;
        logic        e_ls_rvalid;
        logic [31:0] e_ls_rdata;
    } vec_t;

    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        if_req    = 1'b0;
        if_addr   = '0;
        ls_req    = 1'b0;
        ls_we     = 1'b0;
        ls_addr   = '0;
        ls_wdata  = '0;
        ls_be     = '0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
    endtask

    task automatic drive(input vec_t v);
        if_req    = v.if_req;
        if_addr   = v.if_addr;
        ls_req    = v.ls_req;
        ls_we     = v.ls_we;
        ls_addr   = v.ls_addr;
        ls_wdata  = v.ls_wdata;
        ls_be     = v.ls_be;
        mem_ack   = v.mem_ack;
        mem_rdata = v.mem_rdata;
    endtask

    task automatic check_row(input vec_t v);
        check({v.name, ".if_gnt"},    if_gnt,    v.e_if_gnt);
        check({v.name, ".ls_gnt"},    ls_gnt,    v.e_ls_gnt);
        check({v.name, ".mem_req"},   mem_req,   v.e_mem_req);
        if (v.e_mem_req) begin
            check({v.name, ".mem_we"},    mem_we,    v.e_mem_we);
            check({v.name, ".mem_addr"},  mem_addr,  v.e_mem_addr);
            check({v.name, ".mem_wdata"}, mem_wdata, v.e_mem_wdata);
            check({v.name, ".mem_be"},    mem_be,    v.e_mem_be);
        end
        check({v.name, ".if_rvalid"}, if_rvalid, v.e_if_rvalid);
        check({v.name, ".if_rdata"},  if_rdata,  v.e_if_rdata);
        check({v.name, ".ls_rvalid"}, ls_rvalid, v.e_ls_rvalid);
        check({v.name, ".ls_rdata"},  ls_rdata,  v.e_ls_rdata);
        check({v.name, ".if_err"},    if_err,    1'b0);
        check({v.name, ".ls_err"},    ls_err,    1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ls_grants;
        int both_gnt;
        int seen;
        logic got_if;

        // Each row is one cycle: inputs driven after the rising edge, outputs checked at the falling edge.
        //                name                 if_req if_addr  ls_req ls_we ls_addr  ls_wdata      ls_be  ack   mem_rdata     e_ifg e_lsg e_mreq e_mwe e_maddr  e_mwdata      e_mbe  e_ifrv e_if_rdata    e_lsrv e_ls_rdata
        vecs.push_back('{"stray_ack",        1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 32'h00000000, 4'h0, 1'b1, 32'h00001234, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 32'h00000000, 4'h0, 1'b0, 32'h00000000, 1'b0, 32'h00000000});
        vecs.push_back('{"stray_idle",       1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 32'h00000000, 4'h0, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 32'h00000000, 4'h0, 1'b0, 32'h00000000, 1'b0, 32'h00000000});
        vecs.push_back('{"if_gnt",           1'b1, 12'h004, 1'b0, 1'b0, 12'h000, 32'h00000000, 4'h0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 32'h00000000, 4'h0, 1'b0, 32'h00000000, 1'b0, 32'h00000000});
        vecs.push_back('{"if_busy1",         1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 32'h00000000, 4'h0, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0, 12'h004, 32'h00000000, 4'hF, 1'b0, 32'h00000000, 1'b0, 32'h00000000});
        vecs.push_back('{"if_busy2",         1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 32'h00000000, 4'h0, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0, 12'h004, 32'h00000000, 4'hF, 1'b0, 32'h00000000, 1'b0, 32'h00000000});
        vecs.push_back('{"if_ack",           1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 32'h00000000, 4'h0, 1'b1, 32'h00500093, 1'b0, 1'b0, 1'b1, 1'b0, 12'h004, 32'h00000000, 4'hF, 1'b0, 32'h00000000, 1'b0, 32'h00000000});
        vecs.push_back('{"if_rvalid",        1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 32'h00000000, 4'h0, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 32'h00000000, 4'h0, 1'b1, 32'h00500093, 1'b0, 32'h00000000});
        vecs.push_back('{"if_hold",          1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 32'h00000000, 4'h0, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 32'h00000000, 4'h0, 1'b0, 32'h00500093, 1'b0, 32'h00000000});
        vecs.push_back('{"both_req",         1'b1, 12'h008, 1'b1, 1'b1, 12'h100, 32'hDEADBEEF, 4'h3, 1'b0, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b0, 12'h000, 32'h00000000, 4'h0, 1'b0, 32'h00500093, 1'b0, 32'h00000000});
        vecs.push_back('{"st_busy",          1'b1, 12'h008, 1'b0, 1'b0, 12'h000, 32'h00000000, 4'h0, 1'b1, 32'hCAFE0000, 1'b0, 1'b0, 1'b1, 1'b1, 12'h100, 32'hDEADBEEF, 4'h3, 1'b0, 32'h00500093, 1'b0, 32'h00000000});
        vecs.push_back('{"st_rvalid_if_gnt", 1'b1, 12'h008, 1'b0, 1'b0, 12'h000, 32'h00000000, 4'h0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 32'h00000000, 4'h0, 1'b0, 32'h00500093, 1'b1, 32'h00000000});
        vecs.push_back('{"if2_busy",         1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 32'h00000000, 4'h0, 1'b1, 32'h00000013, 1'b0, 1'b0, 1'b1, 1'b0, 12'h008, 32'h00000000, 4'hF, 1'b0, 32'h00500093, 1'b0, 32'h00000000});
        vecs.push_back('{"if2_rvalid",       1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 32'h00000000, 4'h0, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 32'h00000000, 4'h0, 1'b1, 32'h00000013, 1'b0, 32'h00000000});
        vecs.push_back('{"ld_gnt",           1'b0, 12'h000, 1'b1, 1'b0, 12'h200, 32'h00000000, 4'hF, 1'b0, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b0, 12'h000, 32'h00000000, 4'h0, 1'b0, 32'h00000013, 1'b0, 32'h00000000});
        vecs.push_back('{"ld_busy_if_wait",  1'b1, 12'h00C, 1'b0, 1'b0, 12'h000, 32'h00000000, 4'h0, 1'b1, 32'hA5A55A5A, 1'b0, 1'b0, 1'b1, 1'b0, 12'h200, 32'h00000000, 4'hF, 1'b0, 32'h00000013, 1'b0, 32'h00000000});
        vecs.push_back('{"ld_rvalid_if_drop",1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 32'h00000000, 4'h0, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 32'h00000000, 4'h0, 1'b0, 32'h00000013, 1'b1, 32'hA5A55A5A});
        vecs.push_back('{"idle_hold",        1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 32'h00000000, 4'h0, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 32'h00000000, 4'h0, 1'b0, 32'h00000013, 1'b0, 32'hA5A55A5A});

        clear_inputs();
        rst     = 1'b1;
        if_req  = 1'b1;
        if_addr = 12'h004;
        @(negedge clk);
        check("reset.if_gnt",    if_gnt,    1'b0);
        check("reset.mem_req",   mem_req,   1'b0);
        check("reset.mem_addr",  mem_addr,  12'h000);
        check("reset.if_rvalid", if_rvalid, 1'b0);
        check("reset.ls_rvalid", ls_rvalid, 1'b0);
        check("reset.if_rdata",  if_rdata,  32'h0);
        check("reset.wait_cnt",  dut.u_starve.wait_cnt_q, 4'd0);
        clear_inputs();
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            drive(vecs[i]);
            @(negedge clk);
            check_row(vecs[i]);
        end

        // Starvation: LS and IF both request continuously against a zero-wait memory.
        @(posedge clk);
        #1;
        clear_inputs();
        ls_req    = 1'b1;
        ls_addr   = 12'h300;
        ls_be     = 4'hF;
        if_req    = 1'b1;
        if_addr   = 12'h010;
        mem_ack   = 1'b1;
        mem_rdata = 32'h11111111;
        ls_grants = 0;
        both_gnt  = 0;
        got_if    = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (ls_gnt && if_gnt) both_gnt++;
            if (ls_gnt) ls_grants++;
            if (if_gnt) begin
                got_if = 1'b1;
                break;
            end
        end
        check("starve.if_granted", got_if, 1'b1);
        check("starve.ls_grants",  ls_grants, 4);
        check("starve.one_gnt",    both_gnt, 0);
        @(posedge clk);
        #1;
        ls_req = 1'b0;
        if_req = 1'b0;
        check("starve.wait_cnt_clear", dut.u_starve.wait_cnt_q, 4'd0);
        @(posedge clk);
        #1;
        mem_ack = 1'b0;

        // Asynchronous reset in the middle of an LS store.
        @(posedge clk);
        #1;
        ls_req   = 1'b1;
        ls_we    = 1'b1;
        ls_addr  = 12'h3FC;
        ls_wdata = 32'h0BADF00D;
        ls_be    = 4'hC;
        @(negedge clk);
        check("rst_mid.ls_gnt", ls_gnt, 1'b1);
        @(negedge clk);
        check("rst_mid.busy_mem_req", mem_req, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid.mem_req",   mem_req,   1'b0);
        check("rst_mid.ls_gnt_rst", ls_gnt,   1'b0);
        check("rst_mid.ls_rvalid", ls_rvalid, 1'b0);
        clear_inputs();
        @(negedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        mem_ack   = 1'b1;
        mem_rdata = 32'h77777777;
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (ls_rvalid || mem_req) seen++;
        end
        check("rst_mid.no_response", seen, 0);

`ifdef MEM_ARB_TIMEOUT_EN
        // Timeout abort: IF fetch that memory never acknowledges.
        @(posedge clk);
        #1;
        if_req  = 1'b1;
        if_addr = 12'h020;
        @(negedge clk);
        check("timeout.if_gnt", if_gnt, 1'b1);
        @(posedge clk);
        #1;
        if_req = 1'b0;
        seen   = 0;
        got_if = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (if_rvalid) begin
                got_if = 1'b1;
                break;
            end
            if (mem_req) seen++;
        end
        check("timeout.rvalid",      got_if,   1'b1);
        check("timeout.busy_cycles", seen,     8);
        check("timeout.if_err",      if_err,   1'b1);
        check("timeout.if_rdata",    if_rdata, 32'h0);
        check("timeout.mem_req",     mem_req,  1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
